gshare_bp: RTL and testbench
============================

Name: gshare_bp

Overview:
- Parametrised next-generation gshare branch predictor for the fetch stage.
- Replaces single-bit pattern entries with N-bit saturating counters and keeps a speculative global history register (GHR).
- Trains on branch resolution, not by flip-on-mispredict, and repairs the GHR from the checkpoint the ROB/branch-queue returns.
- Maintains saturating lookup/mispredict statistics counters for perf analysis.

Parameters:
- GH_BITS, 8: global history length; must be <= IDX_BITS and >= 2.
- IDX_BITS, 8: PHT index width; PHT depth is 2**IDX_BITS.
- CTR_BITS, 2: saturating counter width, >= 1.
- PC_LSB, 2: lowest PC bit used for indexing (byte offset dropped).
- STAT_BITS, 16: statistics counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- lookup_valid  in  1  fetch presents a branch this cycle
- lookup_pc  in  32  PC of the fetched branch
- pred_valid  out  1  prediction usable this cycle
- pred_taken  out  1  predicted direction (1 = taken)
- pred_gh  out  GH_BITS  GHR value used for this lookup; checkpoint it with the branch
- resolve_valid  in  1  a branch resolved this cycle
- resolve_pc  in  32  PC of the resolved branch
- resolve_gh  in  GH_BITS  checkpointed GHR returned with the branch
- resolve_taken  in  1  actual direction
- resolve_mispredict  in  1  direction mispredicted; qualified by resolve_valid
- ghr_out  out  GH_BITS  current speculative GHR (debug)
- lookup_cnt  out  STAT_BITS  accepted lookups, saturating
- mispred_cnt  out  STAT_BITS  mispredicts, saturating

Behaviour:
- Index: idx = {zero-ext GH} ^ PC[PC_LSB+IDX_BITS-1:PC_LSB]. Lookup uses the GHR; training uses resolve_gh with resolve_pc.
- Counter encoding: taken iff MSB = 1.
- Reset, one cycle, synchronous:
  - every counter = weakly not-taken (2**(CTR_BITS-1))-1; for CTR_BITS=2 this is 01;
  - GHR = 0; lookup_cnt = mispred_cnt = 0;
  - pred_valid = 0 while reset is high.
  - Reset mid-operation discards all state; inputs in the reset cycle are ignored.
- Lookup, zero latency, combinational from registered state:
  - pred_taken = MSB of PHT[idx]; pred_gh = GHR;
  - pred_valid = lookup_valid & !(resolve_valid & resolve_mispredict).
  - When pred_valid = 0, pred_taken is forced to 0.
- GHR update at clock edge, in priority order:
  1. resolve_valid & resolve_mispredict: GHR <= {resolve_gh[GH_BITS-2:0], resolve_taken}. Any same-cycle lookup is squashed and does not shift the GHR.
  2. Else if pred_valid: GHR <= {GHR[GH_BITS-2:0], pred_taken}.
  3. Else hold.
- Training at clock edge, when resolve_valid:
  - PHT[ridx] increments if resolve_taken, else decrements.
  - Saturates at 2**CTR_BITS-1 and at 0; no wrap.
  - Training happens regardless of resolve_mispredict.
- Same-cycle lookup and training to the same index: lookup reads the pre-update value (read-before-write). The new value is visible next cycle.
- Statistics:
  - lookup_cnt increments when pred_valid.
  - mispred_cnt increments when resolve_valid & resolve_mispredict.
  - Both stick at all-ones.
- Only one lookup and one resolve are accepted per cycle; there is no backpressure.

Decomposition:
- Shared package bp_pkg holds:
  - defaults GH_BITS_DEF, IDX_BITS_DEF, CTR_BITS_DEF;
  - typedef bp_ctr_t for the counter;
  - typedef bp_ckpt_t, a struct {gh, pc} carried by the branch queue;
  - function gshare_idx().
- One sub-module, sat_counter_upd: combinational next-value for a CTR_BITS saturating counter, inputs cur and taken. It is reused by future tournament/bimodal predictors.
- PHT is a flop array inside gshare_bp; no SRAM.

Test Plan:
All scenarios use defaults. pc 0x100 maps to idx 0x40.
1. Reset, then lookup_valid=1, pc=0x100 -> pred_valid=1, pred_taken=0, pred_gh=0x00; GHR stays 0x00 after the edge.
2. From reset, two resolves: pc=0x100, gh=0x00, taken=1, mispredict=0. Counter goes 01->10->11; the next lookup at pc 0x100 with GHR 0 gives pred_taken=1; GHR unchanged by the resolves.
3. From counter 11 at idx 0x40, four not-taken resolves -> 10, 01, 00, 00 (saturated); lookup gives pred_taken=0.
4. GHR=0x5A, then in one cycle lookup_valid=1 plus resolve_valid=1, mispredict=1, gh=0x12, taken=1 -> pred_valid=0; next GHR=0x25; lookup_cnt unchanged; mispred_cnt +1.
5. idx 0x40 at 01; same cycle lookup pc=0x100 (GHR 0) and resolve pc=0x100, gh=0, taken=1 -> pred_taken=0 this cycle (old 01, read-before-write); next cycle's lookup at that idx gives pred_taken=1 (counter now 10).
6. After trained state, reset asserted mid-stream with concurrent lookup/resolve -> next cycle all counters 01, GHR 0, stats 0, first lookup predicts not-taken; with STAT_BITS=4, 20 lookups leave lookup_cnt=0xF.

Source files
------------

// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch-prediction blocks of the fetch stage:
//   - default geometry (history length, PHT index width, counter width),
//   - counter and branch-queue checkpoint types,
//   - gshare_idx(): the history-XOR-PC hash used for both lookup and training.
// No ports; imported with "import bp_pkg::*;".
// ----------------------------------------------------------------------------
package bp_pkg;

    localparam int GH_BITS_DEF   = 8;
    localparam int IDX_BITS_DEF  = 8;
    localparam int CTR_BITS_DEF  = 2;
    localparam int PC_LSB_DEF    = 2;
    localparam int STAT_BITS_DEF = 16;

    // Saturating direction counter at the default width.
    typedef logic [CTR_BITS_DEF-1:0] bp_ctr_t;

    // What the branch queue carries alongside each predicted branch so that
    // training and GHR repair can be done at resolve time.
    typedef struct packed {
        logic [GH_BITS_DEF-1:0] gh;
        logic [31:0]            pc;
    } bp_ckpt_t;

    // gshare hash: zero-extended history XOR the PC bits above the byte
    // offset, masked to idx_bits. Works on 32-bit values so one function
    // serves every parameterisation; callers truncate to their index width.
    function automatic logic [31:0] gshare_idx(
        input logic [31:0] gh,
        input logic [31:0] pc,
        input int          pc_lsb,
        input int          idx_bits
    );
        logic [31:0] mask;
        mask = (idx_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << idx_bits) - 32'd1);
        return ((pc >> pc_lsb) ^ gh) & mask;
    endfunction

endpackage

// File: rtl/gshare_bp_if.sv
// ----------------------------------------------------------------------------
// gshare_bp_if
// Lookup / prediction / resolve bundle between fetch + branch queue and the
// gshare predictor.
//   lookup_valid, lookup_pc        : fetch presents a branch
//   pred_valid, pred_taken, pred_gh: same-cycle prediction and GHR checkpoint
//   resolve_valid, resolve_pc,
//   resolve_gh, resolve_taken,
//   resolve_mispredict             : branch resolution from the ROB/branch queue
//
// Handshake: there is no backpressure. A lookup is accepted exactly in the
// cycle pred_valid is high; a resolve is accepted in every cycle
// resolve_valid is high. resolve_mispredict is ignored unless resolve_valid.
//   master : fetch/branch-queue side (drives lookups and resolves)
//   slave  : predictor side
// ----------------------------------------------------------------------------
interface gshare_bp_if
    import bp_pkg::*;
#(
    parameter int GH_BITS = GH_BITS_DEF
);
    logic               lookup_valid;
    logic [31:0]        lookup_pc;
    logic               pred_valid;
    logic               pred_taken;
    logic [GH_BITS-1:0] pred_gh;
    logic               resolve_valid;
    logic [31:0]        resolve_pc;
    logic [GH_BITS-1:0] resolve_gh;
    logic               resolve_taken;
    logic               resolve_mispredict;

    modport master (
        output lookup_valid, lookup_pc,
        output resolve_valid, resolve_pc, resolve_gh, resolve_taken, resolve_mispredict,
        input  pred_valid, pred_taken, pred_gh
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  resolve_valid, resolve_pc, resolve_gh, resolve_taken, resolve_mispredict,
        output pred_valid, pred_taken, pred_gh
    );

endinterface

// File: rtl/sat_counter_upd.sv
// ----------------------------------------------------------------------------
// sat_counter_upd
// Combinational next value of a CTR_BITS-wide saturating direction counter.
//   i_cur   : current counter value
//   i_taken : 1 = count up, 0 = count down
//   o_next  : updated value, clamped at all-ones and at zero (never wraps)
// ----------------------------------------------------------------------------
module sat_counter_upd
    import bp_pkg::*;
#(
    parameter int CTR_BITS = CTR_BITS_DEF
) (
    input  logic [CTR_BITS-1:0] i_cur,
    input  logic                i_taken,
    output logic [CTR_BITS-1:0] o_next
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    always_comb begin
        o_next = i_cur;
        if (i_taken) begin
            if (i_cur != CTR_MAX) begin
                o_next = i_cur + CTR_ONE;
            end
        end else begin
            if (i_cur != CTR_MIN) begin
                o_next = i_cur - CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// ----------------------------------------------------------------------------
// gshare_bp
// gshare branch predictor: a PHT of CTR_BITS saturating counters indexed by
// (speculative GHR XOR PC), a speculative global history register that is
// repaired from the branch-queue checkpoint on mispredict, and saturating
// perf counters.
// Ports:
//   clock, reset  : system clock; synchronous active-high reset
//   bp (slave)    : lookup / prediction / resolve bundle (gshare_bp_if)
//   ghr_out       : current speculative GHR (debug visibility)
//   lookup_cnt    : accepted lookups, saturating
//   mispred_cnt   : resolved mispredicts, saturating
// Constraints: 2 <= GH_BITS <= IDX_BITS, CTR_BITS >= 1.
// ----------------------------------------------------------------------------
module gshare_bp
    import bp_pkg::*;
#(
    parameter int GH_BITS   = GH_BITS_DEF,
    parameter int IDX_BITS  = IDX_BITS_DEF,
    parameter int CTR_BITS  = CTR_BITS_DEF,
    parameter int PC_LSB    = PC_LSB_DEF,
    parameter int STAT_BITS = STAT_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    gshare_bp_if.slave           bp,
    output logic [GH_BITS-1:0]   ghr_out,
    output logic [STAT_BITS-1:0] lookup_cnt,
    output logic [STAT_BITS-1:0] mispred_cnt
);

    localparam int PHT_DEPTH = 1 << IDX_BITS;

    // Weakly not-taken: MSB clear, all lower bits set (01 for 2-bit counters).
    localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;
    localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1);

    logic [CTR_BITS-1:0]  r_pht [PHT_DEPTH];
    logic [GH_BITS-1:0]   r_ghr;
    logic [STAT_BITS-1:0] r_lookup_cnt;
    logic [STAT_BITS-1:0] r_mispred_cnt;

    logic [IDX_BITS-1:0]  w_lkp_idx;
    logic [IDX_BITS-1:0]  w_res_idx;
    logic [CTR_BITS-1:0]  w_lkp_ctr;
    logic [CTR_BITS-1:0]  w_res_ctr;
    logic [CTR_BITS-1:0]  w_res_ctr_next;
    logic                 w_squash;
    logic                 w_pred_valid;
    logic                 w_pred_taken;

    // ------------------------------------------------------------------
    // Indexing: lookups hash the live GHR, training hashes the checkpoint
    // that travelled with the branch so it hits the entry that predicted it.
    // ------------------------------------------------------------------
    assign w_lkp_idx = IDX_BITS'(gshare_idx(32'(r_ghr), bp.lookup_pc, PC_LSB, IDX_BITS));
    assign w_res_idx = IDX_BITS'(gshare_idx(32'(bp.resolve_gh), bp.resolve_pc, PC_LSB, IDX_BITS));

    // Reads come straight from the flops, so a same-cycle training write to
    // the same entry is only seen by the next cycle's lookup.
    assign w_lkp_ctr = r_pht[w_lkp_idx];
    assign w_res_ctr = r_pht[w_res_idx];

    sat_counter_upd #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter_upd (
        .i_cur   (w_res_ctr),
        .i_taken (bp.resolve_taken),
        .o_next  (w_res_ctr_next)
    );

    // ------------------------------------------------------------------
    // Prediction. A mispredict redirect flushes fetch, so a lookup in the
    // same cycle is squashed; nothing is predicted while in reset.
    // ------------------------------------------------------------------
    assign w_squash     = bp.resolve_valid & bp.resolve_mispredict;
    assign w_pred_valid = bp.lookup_valid & ~w_squash & ~reset;
    assign w_pred_taken = w_pred_valid & w_lkp_ctr[CTR_BITS-1];

    assign bp.pred_valid = w_pred_valid;
    assign bp.pred_taken = w_pred_taken;
    assign bp.pred_gh    = r_ghr;

    assign ghr_out     = r_ghr;
    assign lookup_cnt  = r_lookup_cnt;
    assign mispred_cnt = r_mispred_cnt;

    // ------------------------------------------------------------------
    // Pattern history table: trained on every resolve, mispredicted or not.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                r_pht[i] <= CTR_WNT;
            end
        end else if (bp.resolve_valid) begin
            r_pht[w_res_idx] <= w_res_ctr_next;
        end
    end

    // ------------------------------------------------------------------
    // Speculative GHR. Repair wins over speculation: the repaired history is
    // the checkpoint with the branch's actual outcome shifted in.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (w_squash) begin
            r_ghr <= {bp.resolve_gh[GH_BITS-2:0], bp.resolve_taken};
        end else if (w_pred_valid) begin
            r_ghr <= {r_ghr[GH_BITS-2:0], w_pred_taken};
        end
    end

    // ------------------------------------------------------------------
    // Perf counters, sticky at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lookup_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_pred_valid && (r_lookup_cnt != STAT_MAX)) begin
                r_lookup_cnt <= r_lookup_cnt + STAT_ONE;
            end
            if (w_squash && (r_mispred_cnt != STAT_MAX)) begin
                r_mispred_cnt <= r_mispred_cnt + STAT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_gshare_bp.sv
// ----------------------------------------------------------------------------
// tb_gshare_bp
// Directed bench for gshare_bp. u_dut runs with default parameters; u_dut_s4
// uses STAT_BITS=4 to exercise statistics saturation. Inputs change 1 ns
// after the rising edge, outputs are sampled 4 ns after it.
// ----------------------------------------------------------------------------
module tb_gshare_bp;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    gshare_bp_if #(.GH_BITS(8)) bp_if ();
    gshare_bp_if #(.GH_BITS(8)) s4_if ();

    logic [7:0]  ghr_out;
    logic [15:0] lookup_cnt;
    logic [15:0] mispred_cnt;
    logic [7:0]  ghr_out_s4;
    logic [3:0]  lookup_cnt_s4;
    logic [3:0]  mispred_cnt_s4;

    gshare_bp #(
        .GH_BITS(8), .IDX_BITS(8), .CTR_BITS(2), .PC_LSB(2), .STAT_BITS(16)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .bp          (bp_if.slave),
        .ghr_out     (ghr_out),
        .lookup_cnt  (lookup_cnt),
        .mispred_cnt (mispred_cnt)
    );

    gshare_bp #(
        .GH_BITS(8), .IDX_BITS(8), .CTR_BITS(2), .PC_LSB(2), .STAT_BITS(4)
    ) u_dut_s4 (
        .clock       (clock),
        .reset       (reset),
        .bp          (s4_if.slave),
        .ghr_out     (ghr_out_s4),
        .lookup_cnt  (lookup_cnt_s4),
        .mispred_cnt (mispred_cnt_s4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bp_if.lookup_valid       = 1'b0;
        bp_if.lookup_pc          = 32'h0;
        bp_if.resolve_valid      = 1'b0;
        bp_if.resolve_pc         = 32'h0;
        bp_if.resolve_gh         = 8'h0;
        bp_if.resolve_taken      = 1'b0;
        bp_if.resolve_mispredict = 1'b0;
        s4_if.lookup_valid       = 1'b0;
        s4_if.lookup_pc          = 32'h0;
        s4_if.resolve_valid      = 1'b0;
        s4_if.resolve_pc         = 32'h0;
        s4_if.resolve_gh         = 8'h0;
        s4_if.resolve_taken      = 1'b0;
        s4_if.resolve_mispredict = 1'b0;
    endtask

    task automatic drive_lookup(input logic [31:0] pc);
        bp_if.lookup_valid = 1'b1;
        bp_if.lookup_pc    = pc;
    endtask

    task automatic drive_resolve(input logic [31:0] pc, input logic [7:0] gh,
                                 input logic taken, input logic mis);
        bp_if.resolve_valid      = 1'b1;
        bp_if.resolve_pc         = pc;
        bp_if.resolve_gh         = gh;
        bp_if.resolve_taken      = taken;
        bp_if.resolve_mispredict = mis;
    endtask

    // Look at the prediction for pc without letting the lookup be accepted:
    // lookup_valid is dropped again well before the next rising edge.
    task automatic peek(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [7:0] exp_gh);
        drive_lookup(pc);
        #2;
        check({tag, "_taken"}, bp_if.pred_taken, exp_taken);
        check({tag, "_gh"}, bp_if.pred_gh, exp_gh);
        bp_if.lookup_valid = 1'b0;
    endtask

    // One reset cycle with live lookup/resolve traffic that must be ignored,
    // followed by checks of the cleared registered state.
    task automatic do_reset(input string tag);
        next_cycle();
        idle();
        reset = 1'b1;
        drive_lookup(32'h100);
        drive_resolve(32'h100, 8'h00, 1'b1, 1'b1);
        #3;
        check({tag, "_rst_pred_valid"}, bp_if.pred_valid, 1'b0);
        check({tag, "_rst_pred_taken"}, bp_if.pred_taken, 1'b0);
        next_cycle();
        reset = 1'b0;
        idle();
        #3;
        check({tag, "_ghr"}, ghr_out, 8'h00);
        check({tag, "_lookup_cnt"}, lookup_cnt, 16'h0);
        check({tag, "_mispred_cnt"}, mispred_cnt, 16'h0);
    endtask

    logic exp_nt [4];

    initial begin
        idle();
        exp_nt[0] = 1'b1;
        exp_nt[1] = 1'b0;
        exp_nt[2] = 1'b0;
        exp_nt[3] = 1'b0;

        // Power-on reset; pc 0x100 hashes to idx 0x40 with GHR 0.
        do_reset("init");

        // 1. Lookup from reset: weakly not-taken, GHR shifts in a 0.
        next_cycle(); idle(); drive_lookup(32'h100); #3;
        check("s1_pred_valid", bp_if.pred_valid, 1'b1);
        check("s1_pred_taken", bp_if.pred_taken, 1'b0);
        check("s1_pred_gh", bp_if.pred_gh, 8'h00);
        next_cycle(); idle(); #3;
        check("s1_ghr", ghr_out, 8'h00);
        check("s1_lookup_cnt", lookup_cnt, 16'd1);

        // 2. Two taken resolves: 01 -> 10 -> 11, GHR untouched.
        do_reset("s2");
        for (int i = 0; i < 2; i++) begin
            next_cycle(); idle(); drive_resolve(32'h100, 8'h00, 1'b1, 1'b0); #3;
        end
        next_cycle(); idle(); #3;
        check("s2_ghr_after_resolves", ghr_out, 8'h00);
        check("s2_mispred_cnt", mispred_cnt, 16'd0);
        next_cycle(); idle(); drive_lookup(32'h100); #3;
        check("s2_pred_valid", bp_if.pred_valid, 1'b1);
        check("s2_pred_taken", bp_if.pred_taken, 1'b1);
        next_cycle(); idle(); #3;
        check("s2_ghr_after_lookup", ghr_out, 8'h01);

        // 3. Four not-taken resolves from 11: 10, 01, 00, 00. GHR is now 0x01,
        //    so pc 0x104 (0x41 ^ 0x01) reaches idx 0x40.
        for (int i = 0; i < 4; i++) begin
            next_cycle(); idle(); drive_resolve(32'h100, 8'h00, 1'b0, 1'b0); #3;
            next_cycle(); idle();
            peek($sformatf("s3_nt%0d", i), 32'h104, exp_nt[i], 8'h01);
        end
        next_cycle(); idle(); drive_lookup(32'h104); #3;
        check("s3_pred_valid", bp_if.pred_valid, 1'b1);
        check("s3_pred_taken", bp_if.pred_taken, 1'b0);
        next_cycle(); idle(); #3;
        check("s3_ghr", ghr_out, 8'h02);
        check("s3_lookup_cnt", lookup_cnt, 16'd2);

        // 4. Repair to 0x5A ({0x2D, 0}), then a squashed lookup with a
        //    mispredict repair ({0x12[6:0], 1} = 0x25).
        next_cycle(); idle(); drive_resolve(32'h200, 8'h2D, 1'b0, 1'b1); #3;
        next_cycle(); idle(); #3;
        check("s4_ghr_5a", ghr_out, 8'h5A);
        check("s4_mispred_cnt_1", mispred_cnt, 16'd1);
        next_cycle(); idle();
        drive_lookup(32'h100);
        drive_resolve(32'h200, 8'h12, 1'b1, 1'b1);
        #3;
        check("s4_pred_valid", bp_if.pred_valid, 1'b0);
        check("s4_pred_taken", bp_if.pred_taken, 1'b0);
        check("s4_pred_gh", bp_if.pred_gh, 8'h5A);
        next_cycle(); idle(); #3;
        check("s4_ghr_25", ghr_out, 8'h25);
        check("s4_lookup_cnt", lookup_cnt, 16'd2);
        check("s4_mispred_cnt_2", mispred_cnt, 16'd2);

        // 5. Read-before-write on idx 0x40, then squash forcing pred_taken low.
        do_reset("s5");
        next_cycle(); idle();
        drive_lookup(32'h100);
        drive_resolve(32'h100, 8'h00, 1'b1, 1'b0);
        #3;
        check("s5_rbw_valid", bp_if.pred_valid, 1'b1);
        check("s5_rbw_taken", bp_if.pred_taken, 1'b0);
        next_cycle(); idle(); drive_lookup(32'h100); #3;
        check("s5_after_write_taken", bp_if.pred_taken, 1'b1);
        check("s5_after_write_gh", bp_if.pred_gh, 8'h00);
        // GHR is now 0x01; pc 0x104 hits idx 0x40 (counter 10) but is squashed.
        next_cycle(); idle();
        drive_lookup(32'h104);
        drive_resolve(32'h300, 8'h00, 1'b0, 1'b1);
        #3;
        check("s5_squash_valid", bp_if.pred_valid, 1'b0);
        check("s5_squash_taken", bp_if.pred_taken, 1'b0);
        next_cycle(); idle(); #3;
        check("s5_squash_ghr", ghr_out, 8'h00);
        check("s5_lookup_cnt", lookup_cnt, 16'd2);
        check("s5_mispred_cnt", mispred_cnt, 16'd1);

        // 6. Mid-stream reset with live traffic wipes trained state.
        do_reset("s6");
        next_cycle(); idle();
        peek("s6_idx40", 32'h100, 1'b0, 8'h00);
        next_cycle(); idle();
        peek("s6_idxff", 32'h3FC, 1'b0, 8'h00);
        next_cycle(); idle(); drive_lookup(32'h100); #3;
        check("s6_first_lookup_valid", bp_if.pred_valid, 1'b1);
        check("s6_first_lookup_taken", bp_if.pred_taken, 1'b0);

        // Statistics saturation on the STAT_BITS=4 instance.
        for (int i = 0; i < 20; i++) begin
            next_cycle(); idle();
            s4_if.lookup_valid = 1'b1;
            s4_if.lookup_pc    = 32'h100 + 32'(i * 4);
            #3;
            if (i == 14) begin
                check("s4bit_lookup_cnt_14", lookup_cnt_s4, 4'hE);
            end
        end
        next_cycle(); idle(); #3;
        check("s4bit_lookup_cnt_sat", lookup_cnt_s4, 4'hF);
        for (int i = 0; i < 20; i++) begin
            next_cycle(); idle();
            s4_if.resolve_valid      = 1'b1;
            s4_if.resolve_pc         = 32'h100;
            s4_if.resolve_gh         = 8'h00;
            s4_if.resolve_taken      = 1'b0;
            s4_if.resolve_mispredict = 1'b1;
            #3;
        end
        next_cycle(); idle(); #3;
        check("s4bit_mispred_cnt_sat", mispred_cnt_s4, 4'hF);
        check("s4bit_lookup_cnt_hold", lookup_cnt_s4, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
